// File: rtl/vfd_pkg.sv
// Shared types and constants for the VFD grid scanner and its GCP generator.
package vfd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLANK,
        S_LATCH,
        S_UNBLANK,
        S_PREFETCH,
        S_SHIFT
    } scan_state_t;

    localparam int GCP_COUNT = 6;
    localparam int GCP_THRESH [GCP_COUNT] = '{72, 144, 192, 216, 240, 256};

    // afbecd order: byte offset inside the 3-byte column group and which nibble-half feeds each slot
    localparam int   SLOT_BYTE [6] = '{0, 2, 0, 2, 1, 1};
    localparam logic SLOT_HI   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    function automatic int total_bits(input int rows, input int grids);
        return rows * 6 + grids;
    endfunction

endpackage

// File: rtl/vfd_gcp_gen.sv
// Gradient control pulse generator: one registered pulse per grayscale threshold crossing.
module vfd_gcp_gen
    import vfd_pkg::*;
#(
    parameter int BIT_W = 9
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             shift_nxt,
    input  logic [BIT_W-1:0] bit_nxt,
    output logic             GCP
);

    logic hit;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < GCP_COUNT; i++) begin
            if (int'(bit_nxt) == GCP_THRESH[i]) hit = 1'b1;
        end
    end

    // Driven from the next bit index so the pulse lines up with the bit it marks
    always_ff @(posedge CLK) begin
        if (RST) GCP <= 1'b0;
        else     GCP <= shift_nxt && hit;
    end

endmodule

// File: rtl/vfd_grid_scanner.sv
// Autonomous VFD grid scanner: blank/latch sequencing, GRAM fetch, 3-lane serial out, GCP.
// Define VFD_DOUBLE_BUF_EN to add the BUF_SEL input and BUF_OFFSET frame-buffer switching.
module vfd_grid_scanner
    import vfd_pkg::*;
#(
    parameter int NUM_GRIDS     = 52,
    parameter int ROWS          = 39,
    parameter int BYTES_PER_ROW = 77,
    parameter int GRID_PERIOD   = 3840,
    parameter int LAT_W         = 5,
    parameter int ADDR_W        = 12
`ifdef VFD_DOUBLE_BUF_EN
    ,
    parameter int BUF_OFFSET    = 3003
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_RE,
    input  logic [7:0]        MEM_DATA,
    output logic [2:0]        SOUT,
    output logic              SCK_EN,
    output logic              BLK,
    output logic              LAT,
    output logic              GCP,
    output logic [5:0]        GRID_NUM,
    output logic              FRAME_START,
    output logic              OVERRUN
`ifdef VFD_DOUBLE_BUF_EN
    ,
    input  logic              BUF_SEL
`endif
);

    localparam int TOTAL     = total_bits(ROWS, NUM_GRIDS);
    localparam int DATA_BITS = ROWS * 6;
    localparam int BIT_W     = $clog2(TOTAL + 1);
    localparam int PER_W     = $clog2(GRID_PERIOD + 1);
    localparam int LAT_CW    = $clog2(LAT_W + 1);

    scan_state_t       state;
    logic [PER_W-1:0]  per_cnt;
    logic              tick;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_nxt;
    logic              shift_nxt;
    logic [LAT_CW-1:0] lat_cnt;
    logic [2:0]        slot;
    logic [2:0]        fetch_slot;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_go;
    logic [5:0]        next_grid;
    logic              first_scan;
    int                buf_offset;
    int                col_base;
    int                grid_idx;
    int                grid_cur;

`ifdef VFD_DOUBLE_BUF_EN
    logic buf_sel_q;
    assign buf_offset = buf_sel_q ? BUF_OFFSET : 0;
`else
    assign buf_offset = 0;
`endif

    assign tick = EN && (per_cnt == PER_W'(GRID_PERIOD - 1));

    always_ff @(posedge CLK) begin
        if (RST || !EN) per_cnt <= '0;
        else if (tick)  per_cnt <= '0;
        else            per_cnt <= per_cnt + 1'b1;
    end

    always_comb begin
        next_grid = GRID_NUM + 6'd1;
        if (first_scan || GRID_NUM == 6'(NUM_GRIDS - 1)) next_grid = '0;
        col_base   = int'(GRID_NUM >> 1) * 3;
        fetch_addr = ADDR_W'(int'(row_base) + col_base + SLOT_BYTE[fetch_slot] + buf_offset);
        fetch_go   = (state == S_UNBLANK) || (state == S_PREFETCH) ||
                     (state == S_SHIFT && bit_cnt < BIT_W'(DATA_BITS - 1));
    end

    always_comb begin
        shift_nxt = 1'b0;
        bit_nxt   = '0;
        if (state == S_PREFETCH) begin
            shift_nxt = 1'b1;
        end else if (state == S_SHIFT && bit_cnt != BIT_W'(TOTAL - 1)) begin
            shift_nxt = 1'b1;
            bit_nxt   = bit_cnt + 1'b1;
        end
    end

    // Data lanes come straight off the GRAM read port: the byte for bit b arrives during bit b
    always_comb begin
        SOUT     = 3'b000;
        grid_idx = int'(bit_cnt) - DATA_BITS;
        grid_cur = int'(GRID_NUM);
        if (state == S_SHIFT) begin
            if (bit_cnt < BIT_W'(DATA_BITS))
                SOUT = SLOT_HI[slot] ? MEM_DATA[5:3] : MEM_DATA[2:0];
            else if (grid_idx == grid_cur ||
                     (grid_idx == grid_cur + 1 && grid_cur + 1 < NUM_GRIDS))
                SOUT = 3'b111;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            BLK         <= 1'b1;
            LAT         <= 1'b0;
            SCK_EN      <= 1'b0;
            MEM_RE      <= 1'b0;
            MEM_ADDR    <= '0;
            GRID_NUM    <= '0;
            FRAME_START <= 1'b0;
            OVERRUN     <= 1'b0;
            first_scan  <= 1'b1;
            bit_cnt     <= '0;
            lat_cnt     <= '0;
            slot        <= '0;
            fetch_slot  <= '0;
            row_base    <= '0;
`ifdef VFD_DOUBLE_BUF_EN
            buf_sel_q   <= 1'b0;
`endif
        end else begin
            FRAME_START <= 1'b0;
            if (tick && state != S_IDLE) OVERRUN <= 1'b1;
            case (state)
                S_IDLE: begin
                    BLK <= ~EN;
                    if (tick) begin
                        state <= S_BLANK;
                        BLK   <= 1'b1;
                    end
                end
                S_BLANK: begin
`ifdef VFD_DOUBLE_BUF_EN
                    if (next_grid == 6'd0) buf_sel_q <= BUF_SEL;
`endif
                    state   <= S_LATCH;
                    LAT     <= 1'b1;
                    lat_cnt <= '0;
                end
                S_LATCH: begin
                    if (lat_cnt == LAT_CW'(LAT_W - 1)) begin
                        state       <= S_UNBLANK;
                        LAT         <= 1'b0;
                        BLK         <= 1'b0;
                        GRID_NUM    <= next_grid;
                        FRAME_START <= (next_grid == 6'd0);
                        first_scan  <= 1'b0;
                        fetch_slot  <= '0;
                        row_base    <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                S_UNBLANK: begin
                    state <= S_PREFETCH;
                end
                S_PREFETCH: begin
                    state   <= S_SHIFT;
                    SCK_EN  <= 1'b1;
                    bit_cnt <= '0;
                    slot    <= '0;
                end
                S_SHIFT: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    slot    <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
                    if (bit_cnt == BIT_W'(TOTAL - 1)) begin
                        state  <= S_IDLE;
                        SCK_EN <= 1'b0;
                        BLK    <= ~EN;
                    end
                end
                default: state <= S_IDLE;
            endcase

            MEM_RE   <= fetch_go;
            MEM_ADDR <= fetch_go ? fetch_addr : '0;
            if (fetch_go) begin
                if (fetch_slot == 3'd5) begin
                    fetch_slot <= '0;
                    row_base   <= row_base + ADDR_W'(BYTES_PER_ROW);
                end else begin
                    fetch_slot <= fetch_slot + 3'd1;
                end
            end
        end
    end

    vfd_gcp_gen #(.BIT_W(BIT_W)) u_gcp (
        .CLK       (CLK),
        .RST       (RST),
        .shift_nxt (shift_nxt),
        .bit_nxt   (bit_nxt),
        .GCP       (GCP)
    );

endmodule

// File: tb/tb_vfd_grid_scanner.sv
// Directed bench for vfd_grid_scanner: scan framing, pixel reorder, grid bits, GCP, overrun, reset.
`timescale 1ns/1ps
module tb_vfd_grid_scanner;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN  = 1'b0;
    logic [11:0] MEM_ADDR;
    logic        MEM_RE;
    logic [7:0]  MEM_DATA = 8'h00;
    logic [2:0]  SOUT;
    logic        SCK_EN, BLK, LAT, GCP, FRAME_START, OVERRUN;
    logic [5:0]  GRID_NUM;
    logic        BUF_SEL = 1'b0;

    logic        rst_o = 1'b1;
    logic        en_o  = 1'b0;
    logic [7:0]  ovr_data = 8'h00;
    logic [11:0] ovr_addr;
    logic [2:0]  ovr_sout;
    logic [5:0]  ovr_grid;
    logic        ovr_re, ovr_sck, ovr_blk, ovr_lat, ovr_gcp, ovr_fs, ovr_overrun;

    logic [7:0]  gram [4096];

    int checks = 0;
    int errors = 0;

    int scan_blk, scan_lat, scan_sck, gcp_total, gcp_n, fs_count, fs_grid, scan_grid;
    int start_ok;
    logic [2:0] sout_log [300];
    int gcp_idx [8];

    int ovr_run = 0;
    int ovr_runs = 0;
    int ovr_bad_runs = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (MEM_RE) MEM_DATA <= gram[MEM_ADDR];

    vfd_grid_scanner #(.GRID_PERIOD(400)) u_dut (
        .CLK         (CLK),
        .RST         (RST),
        .EN          (EN),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_RE      (MEM_RE),
        .MEM_DATA    (MEM_DATA),
        .SOUT        (SOUT),
        .SCK_EN      (SCK_EN),
        .BLK         (BLK),
        .LAT         (LAT),
        .GCP         (GCP),
        .GRID_NUM    (GRID_NUM),
        .FRAME_START (FRAME_START),
        .OVERRUN     (OVERRUN)
`ifdef VFD_DOUBLE_BUF_EN
        ,
        .BUF_SEL     (BUF_SEL)
`endif
    );

    vfd_grid_scanner #(.GRID_PERIOD(200)) u_ovr (
        .CLK         (CLK),
        .RST         (rst_o),
        .EN          (en_o),
        .MEM_ADDR    (ovr_addr),
        .MEM_RE      (ovr_re),
        .MEM_DATA    (ovr_data),
        .SOUT        (ovr_sout),
        .SCK_EN      (ovr_sck),
        .BLK         (ovr_blk),
        .LAT         (ovr_lat),
        .GCP         (ovr_gcp),
        .GRID_NUM    (ovr_grid),
        .FRAME_START (ovr_fs),
        .OVERRUN     (ovr_overrun)
`ifdef VFD_DOUBLE_BUF_EN
        ,
        .BUF_SEL     (1'b0)
`endif
    );

    // Length of every SCK_EN burst on the overlapping-period instance
    always @(negedge CLK) begin
        if (rst_o) begin
            ovr_run = 0;
        end else if (ovr_sck) begin
            ovr_run++;
        end else if (ovr_run != 0) begin
            ovr_runs++;
            if (ovr_run != 286) ovr_bad_runs++;
            ovr_run = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_val, input logic en_val, input int cycles);
        RST = rst_val;
        EN  = en_val;
        repeat (cycles) @(negedge CLK);
    endtask

    // Waits for BLANK, then records one whole scan; drop_at >= 0 deasserts EN at that shift index
    task automatic captureScan(input int drop_at);
        int guard;
        bit seen;
        scan_blk = 0; scan_lat = 0; scan_sck = 0; gcp_total = 0; gcp_n = 0;
        fs_count = 0; fs_grid = -1; scan_grid = -1; seen = 0;
        guard = 0;
        while (BLK !== 1'b1 && guard < 1000) begin
            @(negedge CLK);
            guard++;
        end
        start_ok = (guard < 1000) ? 1 : 0;
        guard = 0;
        while (guard < 600) begin
            if (BLK && !seen) scan_blk++;
            if (LAT) scan_lat++;
            if (GCP) gcp_total++;
            if (FRAME_START) begin
                fs_count++;
                fs_grid = int'(GRID_NUM);
            end
            if (SCK_EN) begin
                if (scan_sck < 300) sout_log[scan_sck] = SOUT;
                if (GCP && gcp_n < 8) begin
                    gcp_idx[gcp_n] = scan_sck;
                    gcp_n++;
                end
                if (scan_sck == drop_at) EN = 1'b0;
                scan_grid = int'(GRID_NUM);
                scan_sck++;
                seen = 1;
            end else if (seen) begin
                break;
            end
            @(negedge CLK);
            guard++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int sevens;
        logic [2:0] exp_first [6];
        logic [2:0] exp_g0 [6];
        logic [2:0] exp_g51 [6];
        int guard;

        for (int i = 0; i < 4096; i++) gram[i] = 8'h00;
        gram[0]    = 8'h2C; gram[1]    = 8'h15; gram[2]    = 8'h3A;
        gram[75]   = 8'h3F; gram[76]   = 8'h00; gram[77]   = 8'h07;
        gram[3003] = 8'h3F; gram[3004] = 8'h00; gram[3005] = 8'h07;
        exp_first = '{3'd5, 3'd2, 3'd4, 3'd7, 3'd2, 3'd5};
        exp_g51   = '{3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0};
`ifdef VFD_DOUBLE_BUF_EN
        exp_g0    = exp_g51;
`else
        exp_g0    = exp_first;
`endif

        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("rst_sout", SOUT, 0);
        checkOutput("rst_sck_en", SCK_EN, 0);
        checkOutput("rst_lat", LAT, 0);
        checkOutput("rst_gcp", GCP, 0);
        checkOutput("rst_mem_re", MEM_RE, 0);
        checkOutput("rst_mem_addr", MEM_ADDR, 0);
        checkOutput("rst_blk", BLK, 1);
        checkOutput("rst_grid_num", GRID_NUM, 0);
        checkOutput("rst_frame_start", FRAME_START, 0);
        checkOutput("rst_overrun", OVERRUN, 0);
        checkOutput("rst_ovr_overrun", ovr_overrun, 0);

        rst_o = 1'b0;
        en_o  = 1'b1;
        applyStimulus(1'b0, 1'b1, 2);
        checkOutput("idle_blk_enabled", BLK, 0);

        captureScan(-1);
        checkOutput("s0_start", start_ok, 1);
        checkOutput("s0_blk_cycles", scan_blk, 6);
        checkOutput("s0_lat_cycles", scan_lat, 5);
        checkOutput("s0_sck_cycles", scan_sck, 286);
        checkOutput("s0_frame_count", fs_count, 1);
        checkOutput("s0_frame_grid", fs_grid, 0);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("s0_sout_%0d", i), sout_log[i], exp_first[i]);
        checkOutput("s0_sout_6", sout_log[6], 0);
        checkOutput("s0_sout_233", sout_log[233], 0);
        checkOutput("s0_grid_bit0", sout_log[234], 7);
        checkOutput("s0_grid_bit1", sout_log[235], 7);
        checkOutput("s0_grid_bit2", sout_log[236], 0);
        checkOutput("s0_gcp_total", gcp_total, 6);
        checkOutput("s0_gcp_0", gcp_idx[0], 72);
        checkOutput("s0_gcp_1", gcp_idx[1], 144);
        checkOutput("s0_gcp_2", gcp_idx[2], 192);
        checkOutput("s0_gcp_3", gcp_idx[3], 216);
        checkOutput("s0_gcp_4", gcp_idx[4], 240);
        checkOutput("s0_gcp_5", gcp_idx[5], 256);

        for (int k = 1; k <= 50; k++) begin
            captureScan(-1);
            checkOutput($sformatf("grid_seq_%0d", k), scan_grid, k);
        end

        BUF_SEL = 1'b1;
        captureScan(-1);
        checkOutput("g51_grid", scan_grid, 51);
        checkOutput("g51_frame_count", fs_count, 0);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("g51_sout_%0d", i), sout_log[i], exp_g51[i]);
        sevens = 0;
        for (int i = 234; i < 286; i++) if (sout_log[i] == 3'd7) sevens++;
        checkOutput("g51_grid_ones", sevens, 1);
        checkOutput("g51_grid_bit51", sout_log[285], 7);
        checkOutput("g51_grid_bit0", sout_log[234], 0);

        captureScan(-1);
        checkOutput("wrap_grid", scan_grid, 0);
        checkOutput("wrap_frame_count", fs_count, 1);
        checkOutput("wrap_frame_grid", fs_grid, 0);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("wrap_sout_%0d", i), sout_log[i], exp_g0[i]);

        captureScan(100);
        checkOutput("endrop_sck_cycles", scan_sck, 286);
        checkOutput("endrop_blk_end", BLK, 1);
        repeat (3) @(negedge CLK);
        checkOutput("endrop_blk_idle", BLK, 1);
        checkOutput("endrop_sck_idle", SCK_EN, 0);
        checkOutput("endrop_grid", GRID_NUM, 1);
        checkOutput("main_no_overrun", OVERRUN, 0);

        checkOutput("ovr_flag", ovr_overrun, 1);
        checkOutput("ovr_bad_runs", ovr_bad_runs, 0);
        checkOutput("ovr_runs_seen", (ovr_runs >= 5) ? 1 : 0, 1);
        rst_o = 1'b1;
        repeat (2) @(negedge CLK);
        checkOutput("ovr_cleared", ovr_overrun, 0);

        applyStimulus(1'b0, 1'b1, 2);
        guard = 0;
        while (SCK_EN !== 1'b1 && guard < 1000) begin
            @(negedge CLK);
            guard++;
        end
        checkOutput("midrst_scan_seen", (guard < 1000) ? 1 : 0, 1);
        repeat (10) @(negedge CLK);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("midrst_sck_en", SCK_EN, 0);
        checkOutput("midrst_blk", BLK, 1);
        checkOutput("midrst_mem_re", MEM_RE, 0);
        checkOutput("midrst_mem_addr", MEM_ADDR, 0);
        checkOutput("midrst_sout", SOUT, 0);
        checkOutput("midrst_grid", GRID_NUM, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
